// File: rtl/mc6502_interrupt_controller.sv
// mc6502_interrupt_controller: IRQ/NMI/BRK/reset sequencer that stacks PC and PSR and fetches the vector
// Ports: clk, rst (sync, active-high); i_irq_x (active-low level IRQs, bit 0 highest priority);
// i_nmi_x (active-low, falling-edge NMI); mc2il_ack/brk/data from the core; il2mc_addr/read/write/data/busy
// to memory and core; rf2il_s/psr/pc from the register file; il2rf_data/set_pcl/set_pch/pushed/set_i
// to the register file; o_irq_id holds the last accepted IRQ channel.
// Build option: define MC6502_IL_VECTORED_IRQ_EN to give IRQ channel k its own vector at $FFE0+2k.
module mc6502_interrupt_controller #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] i_irq_x,
  input  logic               i_nmi_x,
  input  logic               mc2il_ack,
  input  logic               mc2il_brk,
  input  logic [7:0]         mc2il_data,
  output logic [15:0]        il2mc_addr,
  output logic               il2mc_read,
  output logic               il2mc_write,
  output logic [7:0]         il2mc_data,
  output logic               il2mc_busy,
  input  logic [7:0]         rf2il_s,
  input  logic [7:0]         rf2il_psr,
  input  logic [15:0]        rf2il_pc,
  output logic [7:0]         il2rf_data,
  output logic               il2rf_set_pcl,
  output logic               il2rf_set_pch,
  output logic               il2rf_pushed,
  output logic               il2rf_set_i,
  output logic [2:0]         o_irq_id
);
  typedef enum logic [2:0] {IDLE, PUSH_PCH, PUSH_PCL, PUSH_PSR, VEC_LO, VEC_HI} state_t;
  state_t state;
  logic [15:0] vec, pc_q, irq_vec;
  logic [7:0] s_q, psr_q;
  logic brk_q, nmi_q, nmi_pending;
  logic [2:0] irq_id_q, irq_sel;
  logic irq_any, nmi_edge, accept, take_nmi, take_brk, take_irq, hijack, push, vrd;
  always_comb begin
    irq_any = 1'b0;
    irq_sel = 3'd0;
    for (int k = NUM_IRQ - 1; k >= 0; k--)
      if (!i_irq_x[k]) begin
        irq_any = 1'b1;
        irq_sel = 3'(k);
      end
  end
  assign nmi_edge = nmi_q & ~i_nmi_x;
  assign accept = state == IDLE && mc2il_ack && (nmi_pending || mc2il_brk || (irq_any && !rf2il_psr[2]));
  assign take_nmi = accept && nmi_pending;
  assign take_brk = accept && !nmi_pending && mc2il_brk;
  assign take_irq = accept && !nmi_pending && !mc2il_brk;
  // An NMI seen before the vector fetch of a BRK/IRQ sequence redirects it to the NMI vector.
  assign hijack = (state == PUSH_PCH || state == PUSH_PCL || state == PUSH_PSR) &&
                  vec != 16'hFFFA && (nmi_pending || nmi_edge);
`ifdef MC6502_IL_VECTORED_IRQ_EN
  assign irq_vec = 16'hFFE0 + {12'd0, irq_sel, 1'b0};
`else
  assign irq_vec = 16'hFFFE;
`endif
  // Reset parks the FSM in VEC_LO so the reset vector is fetched right after rst falls.
  always_ff @(posedge clk)
    if (rst) begin
      state       <= VEC_LO;
      vec         <= 16'hFFFC;
      nmi_q       <= 1'b1;
      nmi_pending <= 1'b0;
      irq_id_q    <= 3'd0;
      brk_q       <= 1'b0;
      pc_q        <= 16'd0;
      s_q         <= 8'd0;
      psr_q       <= 8'd0;
    end else begin
      nmi_q       <= i_nmi_x;
      nmi_pending <= take_nmi ? nmi_edge : hijack ? 1'b0 : nmi_pending | nmi_edge;
      state       <= (state == VEC_HI || (state == IDLE && !accept)) ? IDLE : state_t'(state + 3'd1);
      if (accept) begin
        pc_q  <= rf2il_pc;
        s_q   <= rf2il_s;
        psr_q <= rf2il_psr;
        brk_q <= take_brk;
        vec   <= take_nmi ? 16'hFFFA : take_brk ? 16'hFFFE : irq_vec;
      end else if (hijack)
        vec <= 16'hFFFA;
      if (take_irq)
        irq_id_q <= irq_sel;
    end
  assign push          = !rst && (state == PUSH_PCH || state == PUSH_PCL || state == PUSH_PSR);
  assign vrd           = !rst && (state == VEC_LO || state == VEC_HI);
  assign il2mc_busy    = !rst && state != IDLE;
  assign il2mc_write   = push;
  assign il2rf_pushed  = push;
  assign il2mc_read    = vrd;
  assign il2rf_set_pcl = !rst && state == VEC_LO;
  assign il2rf_set_pch = !rst && state == VEC_HI;
  assign il2rf_set_i   = !rst && state == VEC_HI;
  assign il2rf_data    = vrd ? mc2il_data : 8'h00;
  assign o_irq_id      = rst ? 3'd0 : irq_id_q;
  always_comb begin
    il2mc_addr = rst                ? 16'h0000 :
                 state == PUSH_PCH  ? {8'h01, s_q} :
                 state == PUSH_PCL  ? {8'h01, s_q - 8'd1} :
                 state == PUSH_PSR  ? {8'h01, s_q - 8'd2} :
                 state == VEC_LO    ? vec :
                 state == VEC_HI    ? vec + 16'd1 : 16'h0000;
    il2mc_data = rst                ? 8'h00 :
                 state == PUSH_PCH  ? pc_q[15:8] :
                 state == PUSH_PCL  ? pc_q[7:0] :
                 state == PUSH_PSR  ? {psr_q[7:6], 1'b1, brk_q, psr_q[3:0]} : 8'h00;
  end
endmodule

// File: tb/tb_mc6502_interrupt_controller.sv
// tb_mc6502_interrupt_controller: randomized and directed bench against a queue-based sequence model
module tb_mc6502_interrupt_controller;
  localparam int N = 4;
  logic clk = 0, rst = 1;
  logic [N-1:0] i_irq_x = '1;
  logic i_nmi_x = 1, mc2il_ack = 0, mc2il_brk = 0;
  logic [7:0] mc2il_data = 0, rf2il_s = 8'hFF, rf2il_psr = 0;
  logic [15:0] rf2il_pc = 0;
  logic [15:0] il2mc_addr;
  logic il2mc_read, il2mc_write, il2mc_busy, il2rf_set_pcl, il2rf_set_pch, il2rf_pushed, il2rf_set_i;
  logic [7:0] il2mc_data, il2rf_data;
  logic [2:0] o_irq_id;
  int errors = 0, checks = 0;
  typedef struct { int kind; logic [15:0] addr; logic [7:0] data; } ent_t;
  ent_t q[$];
  logic [15:0] m_vec = 0;
  bit m_nmi_seq = 0, m_pend = 0, m_prev = 1;
  logic [2:0] m_id = 0;

  mc6502_interrupt_controller #(.NUM_IRQ(N)) dut (
    .clk(clk), .rst(rst), .i_irq_x(i_irq_x), .i_nmi_x(i_nmi_x),
    .mc2il_ack(mc2il_ack), .mc2il_brk(mc2il_brk), .mc2il_data(mc2il_data),
    .il2mc_addr(il2mc_addr), .il2mc_read(il2mc_read), .il2mc_write(il2mc_write),
    .il2mc_data(il2mc_data), .il2mc_busy(il2mc_busy),
    .rf2il_s(rf2il_s), .rf2il_psr(rf2il_psr), .rf2il_pc(rf2il_pc),
    .il2rf_data(il2rf_data), .il2rf_set_pcl(il2rf_set_pcl), .il2rf_set_pch(il2rf_set_pch),
    .il2rf_pushed(il2rf_pushed), .il2rf_set_i(il2rf_set_i), .o_irq_id(o_irq_id)
  );

  always #5 clk = ~clk;

  function automatic logic [41:0] obs();
    return {il2mc_busy, il2mc_read, il2mc_write, il2rf_pushed, il2rf_set_pcl, il2rf_set_pch,
            il2rf_set_i, il2mc_addr, il2mc_data, il2rf_data, o_irq_id};
  endfunction

  function automatic logic [41:0] expv();
    if (rst) return 42'd0;
    if (q.size() == 0) return {7'd0, 16'd0, 8'd0, 8'd0, m_id};
    if (q[0].kind == 0) return {7'b1011000, q[0].addr, q[0].data, 8'd0, m_id};
    if (q[0].kind == 1) return {7'b1100100, m_vec, 8'd0, mc2il_data, m_id};
    return {7'b1100011, m_vec + 16'd1, 8'd0, mc2il_data, m_id};
  endfunction

  function automatic void start(logic [15:0] v, bit brk, bit nmi);
    m_vec = v;
    m_nmi_seq = nmi;
    q.push_back('{0, {8'h01, rf2il_s}, rf2il_pc[15:8]});
    q.push_back('{0, {8'h01, 8'(rf2il_s - 1)}, rf2il_pc[7:0]});
    q.push_back('{0, {8'h01, 8'(rf2il_s - 2)}, (rf2il_psr & 8'hCF) | 8'h20 | (brk ? 8'h10 : 8'h00)});
    q.push_back('{1, 16'h0, 8'h0});
    q.push_back('{2, 16'h0, 8'h0});
  endfunction

  task automatic tick();
    bit idle = (q.size() == 0);
    bit was_push = !idle && q[0].kind == 0;
    bit e;
    int k = -1;
    for (int i = 0; i < N; i++) if (!i_irq_x[i] && k < 0) k = i;
    if (rst) begin
      q.delete();
      q.push_back('{1, 16'h0, 8'h0});
      q.push_back('{2, 16'h0, 8'h0});
      m_vec = 16'hFFFC; m_nmi_seq = 0; m_pend = 0; m_prev = 1; m_id = 0;
    end else begin
      e = m_prev && !i_nmi_x;
      m_prev = i_nmi_x;
      if (!idle) void'(q.pop_front());
      if (idle && mc2il_ack && m_pend) begin
        start(16'hFFFA, 0, 1);
        m_pend = e;
      end else if (idle && mc2il_ack && mc2il_brk) begin
        start(16'hFFFE, 1, 0);
        m_pend = m_pend | e;
      end else if (idle && mc2il_ack && k >= 0 && !rf2il_psr[2]) begin
        m_id = 3'(k);
`ifdef MC6502_IL_VECTORED_IRQ_EN
        start(16'hFFE0 + 16'(2 * k), 0, 0);
`else
        start(16'hFFFE, 0, 0);
`endif
        m_pend = m_pend | e;
      end else if (was_push && !m_nmi_seq && (m_pend || e)) begin
        m_vec = 16'hFFFA; m_nmi_seq = 1; m_pend = 0;
      end else
        m_pend = m_pend | e;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mc2il_data = 8'h89;
    for (int c = 0; c < 6; c++) begin
      rst = c < 2;
      #1; checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL reset c%0d got=%h exp=%h", c, obs(), expv()); end
      if (c == 2) begin
        checks++;
        if (il2mc_addr !== 16'hFFFC || il2rf_set_pcl !== 1'b1 || il2rf_pushed !== 1'b0 || il2rf_data !== 8'h89) begin
          errors++;
          $display("FAIL reset_vec_lo addr=%h pcl=%b pushed=%b data=%h exp fffc 1 0 89", il2mc_addr, il2rf_set_pcl, il2rf_pushed, il2rf_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_irq();
    rf2il_psr = 8'h00; rf2il_s = 8'hFF; rf2il_pc = 16'h1234; i_irq_x = 4'b1101;
    for (int c = 0; c < 8; c++) begin
      mc2il_ack = c == 0; mc2il_data = 8'($urandom);
      #1; checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL irq c%0d got=%h exp=%h", c, obs(), expv()); end
      if (c == 1) begin
        checks++;
        if (il2mc_addr !== 16'h01FF || il2mc_data !== 8'h12) begin errors++; $display("FAIL irq_pch got=%h/%h exp=01ff/12", il2mc_addr, il2mc_data); end
      end
      if (c == 3) begin
        checks++;
        if (il2mc_addr !== 16'h01FD || il2mc_data !== 8'h20) begin errors++; $display("FAIL irq_psr got=%h/%h exp=01fd/20", il2mc_addr, il2mc_data); end
      end
      tick();
    end
    checks++;
    if (o_irq_id !== 3'd1) begin errors++; $display("FAIL irq_id got=%0d exp=1", o_irq_id); end
    i_irq_x = '1;
  endtask

  task automatic test_masked();
    rf2il_psr = 8'h04; i_irq_x = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      mc2il_ack = 1;
      #1; checks++;
      if (obs() !== expv() || il2mc_busy !== 1'b0) begin errors++; $display("FAIL masked c%0d got=%h exp=%h", c, obs(), expv()); end
      tick();
    end
    rf2il_psr = 8'h00; i_irq_x = 4'b1011;
    for (int c = 0; c < 8; c++) begin
      mc2il_ack = c == 0;
      #1; checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL irq2 c%0d got=%h exp=%h", c, obs(), expv()); end
      tick();
    end
    checks++;
    if (o_irq_id !== 3'd2) begin errors++; $display("FAIL irq2_id got=%0d exp=2", o_irq_id); end
    i_irq_x = '1;
  endtask

  task automatic test_nmi();
    rf2il_psr = 8'h04; rf2il_pc = 16'hBEEF; rf2il_s = 8'h80;
    for (int c = 0; c < 14; c++) begin
      mc2il_ack = c == 0 || c == 6; mc2il_brk = c == 0; i_nmi_x = c != 4;
      #1; checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL nmi_pend c%0d got=%h exp=%h", c, obs(), expv()); end
      if (c == 10) begin
        checks++;
        if (il2mc_addr !== 16'hFFFA) begin errors++; $display("FAIL nmi_vec got=%h exp=fffa", il2mc_addr); end
      end
      tick();
    end
    for (int c = 0; c < 9; c++) begin
      mc2il_ack = c == 0 || c == 7; mc2il_brk = c == 0; i_nmi_x = c != 2;
      #1; checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL nmi_hijack c%0d got=%h exp=%h", c, obs(), expv()); end
      if (c == 3) begin
        checks++;
        if (il2mc_data[4] !== 1'b1) begin errors++; $display("FAIL hijack_brkbit got=%b exp=1", il2mc_data[4]); end
      end
      if (c == 4) begin
        checks++;
        if (il2mc_addr !== 16'hFFFA) begin errors++; $display("FAIL hijack_vec got=%h exp=fffa", il2mc_addr); end
      end
      tick();
    end
    mc2il_ack = 0; mc2il_brk = 0;
  endtask

  task automatic test_wrap();
    rf2il_s = 8'h00; rf2il_psr = 8'h00; i_irq_x = 4'b1110;
    for (int c = 0; c < 8; c++) begin
      mc2il_ack = c == 0;
      #1; checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL wrap c%0d got=%h exp=%h", c, obs(), expv()); end
      if (c >= 1 && c <= 3) begin
        checks++;
        if (il2mc_addr !== (c == 1 ? 16'h0100 : c == 2 ? 16'h01FF : 16'h01FE)) begin errors++; $display("FAIL wrap_addr c%0d got=%h", c, il2mc_addr); end
      end
      tick();
    end
    for (int c = 0; c < 8; c++) begin
      mc2il_ack = c == 0; rst = c == 2;
      #1; checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL rst_mid c%0d got=%h exp=%h", c, obs(), expv()); end
      if (c == 3) begin
        checks++;
        if (il2mc_addr !== 16'hFFFC || il2mc_write !== 1'b0) begin errors++; $display("FAIL rst_mid_vec got=%h wr=%b exp=fffc 0", il2mc_addr, il2mc_write); end
      end
      tick();
    end
    rst = 0; i_irq_x = '1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = $urandom_range(0, 99) == 0;
      mc2il_ack = 1'($urandom_range(0, 1));
      mc2il_brk = $urandom_range(0, 3) == 0;
      i_nmi_x = $urandom_range(0, 9) != 0;
      i_irq_x = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      mc2il_data = 8'($urandom); rf2il_s = 8'($urandom); rf2il_psr = 8'($urandom); rf2il_pc = 16'($urandom);
      #1; checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL random c%0d got=%h exp=%h", c, obs(), expv()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_irq();
    test_masked();
    test_nmi();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mc6502_interrupt_controller.md
MC6502_INTERRUPT_CONTROLLER -- requirements
Module: mc6502_interrupt_controller

Interface
REQ-001 Parameter NUM_IRQ, default 4 (legal 1..8): number of level-sensitive IRQ channels.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 i_irq_x  input  NUM_IRQ  IRQ requests, active-low, level; bit 0 has the highest priority.
REQ-005 i_nmi_x  input  1  NMI, active-low, falling-edge triggered.
REQ-006 mc2il_ack  input  1  core is at an instruction boundary and can accept a sequence.
REQ-007 mc2il_brk  input  1  BRK opcode decoded; valid with mc2il_ack.
REQ-008 mc2il_data  input  8  memory read data.
REQ-009 il2mc_addr  output  16  memory address.
REQ-010 il2mc_read / il2mc_write  output  1 each  memory strobes.
REQ-011 il2mc_data  output  8  stack push data.
REQ-012 il2mc_busy  output  1  sequence active; core stalls.
REQ-013 rf2il_s  input  8, rf2il_psr  input  8, rf2il_pc  input  16  register file values.
REQ-014 il2rf_data  output  8  equals mc2il_data during vector reads.
REQ-015 il2rf_set_pcl, il2rf_set_pch, il2rf_pushed, il2rf_set_i  output  1 each  register file strobes.
REQ-016 o_irq_id  output  3  index of the last accepted IRQ channel.

Function
REQ-017 States: IDLE, PUSH_PCH, PUSH_PCL, PUSH_PSR, VEC_LO, VEC_HI; each non-IDLE state lasts exactly one cycle; il2mc_busy=1 in every non-IDLE state.
REQ-018 NMI: i_nmi_x is registered each cycle; a 1->0 transition sets nmi_pending; an edge arriving during a sequence stays pending.
REQ-019 Acceptance happens in IDLE with mc2il_ack=1. Priority: NMI pending > mc2il_brk > lowest-index asserted IRQ (only when rf2il_psr[2]=0). The next state is PUSH_PCH.
REQ-020 IRQ is level-sensitive and not latched; a request released before acceptance is not taken.
REQ-021 PUSH_PCH: addr={8'h01,S}, data=PC[15:8]. PUSH_PCL: addr={8'h01,S-1}, data=PC[7:0]. PUSH_PSR: addr={8'h01,S-2}, data=PSR with bit5=1 and bit4=brk.
REQ-022 In each PUSH state: il2mc_write=1 and il2rf_pushed=1; S arithmetic wraps modulo 256 (S=8'h00 writes $0100, $01FF, $01FE).
REQ-023 VEC_LO: il2mc_read=1, addr=vector, il2rf_set_pcl=1. VEC_HI: il2mc_read=1, addr=vector+1, il2rf_set_pch=1, il2rf_set_i=1. Then return to IDLE.
REQ-024 Vectors: reset $FFFC; NMI $FFFA; BRK and IRQ $FFFE (see REQ-031).
REQ-025 NMI hijack: if nmi_pending becomes set in a BRK/IRQ sequence before VEC_LO, the vector becomes $FFFA and nmi_pending clears; otherwise nmi_pending clears on NMI acceptance.
REQ-026 Latency: an ack in cycle N gives PUSH_PCH in N+1 and VEC_HI in N+5; the core may ack again in N+6 at the earliest.
REQ-027 o_irq_id updates at IRQ acceptance only.
REQ-028 Strobes that are inactive in the current state are driven 0; il2mc_addr/il2mc_data are 0 in IDLE.

Reset
REQ-029 While rst=1: all outputs 0, nmi_pending=0, NMI edge register=1, o_irq_id=0; rst mid-sequence aborts it.
REQ-030 The first cycle after rst falls is VEC_LO with vector $FFFC, with no pushes; the next is VEC_HI; then IDLE.

Configuration
REQ-031 MC6502_IL_VECTORED_IRQ_EN defined: IRQ channel k uses vector $FFE0+2k and BRK keeps $FFFE. Undefined: every IRQ channel uses $FFFE and the per-channel decode is absent.

Verification
REQ-032 Reset release, mc2il_data=8'h89 -> read $FFFC set_pcl, read $FFFD set_pch, no il2rf_pushed, then IDLE.
REQ-033 IRQ1 low, PSR=8'h00, S=8'hFF, PC=16'h1234, ack -> writes $01FF=12, $01FE=34, $01FD=20, reads $FFFE/$FFFF (macro on: $FFE2/$FFE3), o_irq_id=1.
REQ-034 IRQ0 and IRQ2 low with PSR[2]=1 -> no sequence; IRQ2 low with PSR[2]=0 -> accepted with o_irq_id=2.
REQ-035 1-cycle i_nmi_x low pulse while busy -> NMI taken at the next ack, reads $FFFA; a BRK ack with NMI edge during PUSH_PCL -> PSR pushed with bit4=1, vector $FFFA.
REQ-036 S=8'h00 -> writes $0100, $01FF, $01FE; rst=1 during PUSH_PCL -> no further writes, reset vector fetch follows.
